ps2_host_tx: RTL and testbench

//  Host-to-device PS/2 transmitter. It sends one command byte to the keyboard,
//  e.g. 0xED "set LEDs" or 0xFF "reset", over the same PS2C/PS2D lines the

---
 rtl/ps2_host_tx.sv | 200 ++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, issues a request-to-send,
// shifts one command byte plus odd parity and stop on device clock falls, then
// checks the device ACK. Both pads are open-drain; outputs only ever pull low.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 6000,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned FILTER_LEN     = 8
) (
    input  logic       mclk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    input  logic       ps2c_in,
    input  logic       ps2d_in,
    output logic       ps2c_oe,
    output logic       ps2d_oe,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam int unsigned CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES
                                                                        : TIMEOUT_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned FLT_W   = $clog2(FILTER_LEN + 1);
    localparam int unsigned IDX_W   = 4;
    localparam int unsigned FRAME_W = 10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_SHIFT,
        S_ACK,
        S_WAIT_IDLE,
        S_DONE,
        S_ERR
    } state_t;

    // Pad index 0 = PS2C, 1 = PS2D
    logic [1:0]       pad_raw;
    logic [1:0]       meta_q;
    logic [1:0]       sync_q;
    logic [1:0]       filt_q;
    logic [FLT_W-1:0] flt_cnt_q [2];
    logic             c_fall_q;

    state_t               state_q,   state_d;
    logic [CNT_W-1:0]     cnt_q,     cnt_d;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic [FRAME_W-1:0]   frame_q,   frame_d;
    logic                 ps2c_oe_q, ps2c_oe_d;
    logic                 ps2d_oe_q, ps2d_oe_d;
    logic                 busy_q,    busy_d;
    logic                 done_q,    done_d;
    logic                 error_q,   error_d;
    logic                 timed_out;

    assign pad_raw = {ps2d_in, ps2c_in};

    // Two-flop synchroniser, then a level filter that only moves after
    // FILTER_LEN consecutive samples disagreeing with the current level
    always_ff @(posedge mclk) begin
        if (rst) begin
            meta_q   <= 2'b11;
            sync_q   <= 2'b11;
            filt_q   <= 2'b11;
            c_fall_q <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                flt_cnt_q[i] <= '0;
            end
        end else begin
            meta_q   <= pad_raw;
            sync_q   <= meta_q;
            c_fall_q <= filt_q[0] && !sync_q[0]
                        && (flt_cnt_q[0] == FLT_W'(FILTER_LEN - 1));
            for (int i = 0; i < 2; i++) begin
                if (sync_q[i] == filt_q[i]) begin
                    flt_cnt_q[i] <= '0;
                end else if (flt_cnt_q[i] == FLT_W'(FILTER_LEN - 1)) begin
                    flt_cnt_q[i] <= '0;
                    filt_q[i]    <= sync_q[i];
                end else begin
                    flt_cnt_q[i] <= flt_cnt_q[i] + FLT_W'(1);
                end
            end
        end
    end

    // FSM and datapath registers
    always_ff @(posedge mclk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            frame_q   <= '0;
            ps2c_oe_q <= 1'b0;
            ps2d_oe_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            frame_q   <= frame_d;
            ps2c_oe_q <= ps2c_oe_d;
            ps2d_oe_q <= ps2d_oe_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            error_q   <= error_d;
        end
    end

    // Next-state and registered-output decode; the REQ cycle is the last
    // cycle of the PS2C inhibit window, so INHIBIT itself lasts one less
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        frame_d   = frame_q;
        ps2d_oe_d = ps2d_oe_q;
        ps2c_oe_d = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        error_d   = 1'b0;
        timed_out = 1'b0;

        if (state_q inside {S_SHIFT, S_ACK, S_WAIT_IDLE}) begin
            cnt_d     = c_fall_q ? '0 : cnt_q + CNT_W'(1);
            timed_out = !c_fall_q && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
        end

        case (state_q)
            S_IDLE: begin
                if (tx_start) begin
                    state_d = S_INHIBIT;
                    cnt_d   = '0;
                    frame_d = {1'b1, ~^tx_data, tx_data};
                end
            end
            S_INHIBIT: begin
                if (cnt_q >= CNT_W'(INHIBIT_CYCLES - 2)) begin
                    state_d   = S_REQ;
                    ps2d_oe_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_REQ: begin
                state_d   = S_SHIFT;
                bit_idx_d = '0;
                cnt_d     = '0;
            end
            S_SHIFT: begin
                if (timed_out) begin
                    state_d = S_ERR;
                end else if (c_fall_q) begin
                    ps2d_oe_d = ~frame_q[bit_idx_q];
                    bit_idx_d = bit_idx_q + IDX_W'(1);
                    if (bit_idx_q == IDX_W'(FRAME_W - 1)) begin
                        state_d = S_ACK;
                    end
                end
            end
            S_ACK: begin
                if (timed_out) begin
                    state_d = S_ERR;
                end else if (c_fall_q) begin
                    state_d = filt_q[1] ? S_ERR : S_WAIT_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                if (timed_out) begin
                    state_d = S_ERR;
                end else if (filt_q == 2'b11) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (!(state_d inside {S_REQ, S_SHIFT})) begin
            ps2d_oe_d = 1'b0;
        end
        ps2c_oe_d = (state_d == S_INHIBIT) || (state_d == S_REQ);
        busy_d    = state_d inside {S_INHIBIT, S_REQ, S_SHIFT, S_ACK, S_WAIT_IDLE};
        done_d    = (state_d == S_DONE);
        error_d   = (state_d == S_ERR);
    end

    assign ps2c_oe = ps2c_oe_q;
    assign ps2d_oe = ps2d_oe_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign error   = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a simple PS/2 device model on the
// open-drain lines (scaled timing: device half-period H mclk cycles).
module tb_ps2_host_tx;

    localparam int unsigned INH   = 60;
    localparam int unsigned TMO   = 500;
    localparam int unsigned FLT   = 8;
    localparam int          H     = 40;
    localparam int          BOUND = 5000;

    logic       mclk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       dev_c;
    logic       dev_d;
    logic       ps2c_in;
    logic       ps2d_in;
    logic       ps2c_oe;
    logic       ps2d_oe;
    logic       busy;
    logic       done;
    logic       error;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    // Wired-AND of device drive and host pull-down
    assign ps2c_in = dev_c & ~ps2c_oe;
    assign ps2d_in = dev_d & ~ps2d_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TMO),
        .FILTER_LEN    (FLT)
    ) dut (
        .mclk    (mclk),
        .rst     (rst),
        .tx_data (tx_data),
        .tx_start(tx_start),
        .ps2c_in (ps2c_in),
        .ps2d_in (ps2d_in),
        .ps2c_oe (ps2c_oe),
        .ps2d_oe (ps2d_oe),
        .busy    (busy),
        .done    (done),
        .error   (error)
    );

    always #10 mclk = ~mclk;

    always @(negedge mclk) begin
        if (done === 1'b1) done_cnt <= done_cnt + 1;
    end

    task automatic start_tx(input logic [7:0] d);
        @(negedge mclk);
        tx_data  = d;
        tx_start = 1'b1;
        @(negedge mclk);
        tx_start = 1'b0;
    endtask

    // Device: waits for inhibit + release, clocks 10 bits (sampling on rise),
    // then an 11th clock with PS2D pulled low if do_ack
    task automatic dev_run(input bit do_ack, input bit glitch,
                           output logic [9:0] bits, output int hi_cycles);
        int t;
        t = 0;
        bits = '0;
        hi_cycles = 0;
        while (ps2c_oe !== 1'b1 && t < BOUND) begin @(negedge mclk); t++; end
        while (ps2c_oe === 1'b1 && t < BOUND) begin hi_cycles++; @(negedge mclk); t++; end
        repeat (H) @(negedge mclk);
        if (glitch) begin
            dev_c = 1'b0;
            repeat (3) @(negedge mclk);
            dev_c = 1'b1;
            repeat (H) @(negedge mclk);
        end
        for (int i = 0; i < 10; i++) begin
            dev_c = 1'b0;
            repeat (H) @(negedge mclk);
            dev_c = 1'b1;
            bits[i] = ps2d_in;
            repeat (H) @(negedge mclk);
        end
        if (do_ack) dev_d = 1'b0;
        repeat (H / 2) @(negedge mclk);
        dev_c = 1'b0;
        repeat (H) @(negedge mclk);
        dev_c = 1'b1;
        repeat (H / 2) @(negedge mclk);
        dev_d = 1'b1;
    endtask

    // Waits (bounded) for the first done/error pulse of a transfer
    task automatic wait_end(output bit got_done, output bit got_err,
                            output logic busy_at, output logic pulse_after);
        int t;
        t = 0;
        got_done = 1'b0;
        got_err = 1'b0;
        busy_at = 1'bx;
        pulse_after = 1'bx;
        while (t < BOUND) begin
            @(negedge mclk);
            t++;
            if (done === 1'b1 || error === 1'b1) begin
                got_done = (done === 1'b1);
                got_err  = (error === 1'b1);
                busy_at  = busy;
                @(negedge mclk);
                pulse_after = done | error;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge mclk);
        n_checks++;
        if ({ps2c_oe, ps2d_oe, busy, done, error} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected 00000",
                     {ps2c_oe, ps2d_oe, busy, done, error});
        end
        rst = 1'b0;
        repeat (5) @(negedge mclk);
    endtask

    task automatic test_basic();
        logic [9:0] bits;
        int hi;
        bit gd, ge;
        logic ba, pa;
        start_tx(8'hED);
        fork
            dev_run(1'b1, 1'b0, bits, hi);
            wait_end(gd, ge, ba, pa);
        join
        n_checks++;
        if (hi !== INH) begin n_fail++; $display("FAIL inhibit_len: got %0d expected %0d", hi, INH); end
        n_checks++;
        if (bits !== 10'h3ED) begin n_fail++; $display("FAIL frame_ED: got %h expected 3ed", bits); end
        n_checks++;
        if (!(gd && !ge)) begin n_fail++; $display("FAIL done_ED: got done=%b err=%b expected done=1 err=0", gd, ge); end
        n_checks++;
        if (ba !== 1'b0) begin n_fail++; $display("FAIL busy_at_done: got %b expected 0", ba); end
        n_checks++;
        if (pa !== 1'b0) begin n_fail++; $display("FAIL done_width: got %b expected 0 one cycle later", pa); end
        repeat (10) @(negedge mclk);
    endtask

    task automatic test_parity();
        logic [9:0] bits;
        int hi;
        bit gd, ge;
        logic ba, pa;
        start_tx(8'h01);
        fork
            dev_run(1'b1, 1'b0, bits, hi);
            wait_end(gd, ge, ba, pa);
        join
        n_checks++;
        if (bits[8] !== 1'b0) begin n_fail++; $display("FAIL parity_01: got %b expected 0", bits[8]); end
        n_checks++;
        if (bits !== 10'h201) begin n_fail++; $display("FAIL frame_01: got %h expected 201", bits); end
        n_checks++;
        if (!(gd && !ge)) begin n_fail++; $display("FAIL done_01: got done=%b err=%b expected done=1 err=0", gd, ge); end
        repeat (10) @(negedge mclk);

        start_tx(8'h00);
        fork
            dev_run(1'b1, 1'b0, bits, hi);
            wait_end(gd, ge, ba, pa);
        join
        n_checks++;
        if (bits[8] !== 1'b1) begin n_fail++; $display("FAIL parity_00: got %b expected 1", bits[8]); end
        n_checks++;
        if (bits !== 10'h300) begin n_fail++; $display("FAIL frame_00: got %h expected 300", bits); end
        n_checks++;
        if (!(gd && !ge)) begin n_fail++; $display("FAIL done_00: got done=%b err=%b expected done=1 err=0", gd, ge); end
        repeat (10) @(negedge mclk);
    endtask

    task automatic test_timeout();
        int t;
        int d0;
        start_tx(8'h55);
        t = 0;
        while (ps2c_oe !== 1'b1 && t < BOUND) begin @(negedge mclk); t++; end
        while (ps2c_oe === 1'b1 && t < BOUND) begin @(negedge mclk); t++; end
        d0 = done_cnt;
        t = 0;
        while (error !== 1'b1 && t < BOUND) begin @(negedge mclk); t++; end
        n_checks++;
        if (t !== TMO) begin n_fail++; $display("FAIL timeout_latency: got %0d expected %0d", t, TMO); end
        n_checks++;
        if ({ps2c_oe, ps2d_oe} !== 2'b00) begin n_fail++; $display("FAIL timeout_oe: got %b expected 00", {ps2c_oe, ps2d_oe}); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL timeout_busy: got %b expected 0", busy); end
        repeat (5) @(negedge mclk);
        n_checks++;
        if (done_cnt !== d0) begin n_fail++; $display("FAIL timeout_no_done: got %0d dones expected 0", done_cnt - d0); end
        repeat (10) @(negedge mclk);
    endtask

    task automatic test_no_ack();
        logic [9:0] bits;
        int hi;
        bit gd, ge;
        logic ba, pa;
        start_tx(8'h3C);
        fork
            dev_run(1'b0, 1'b0, bits, hi);
            wait_end(gd, ge, ba, pa);
        join
        n_checks++;
        if (!(ge && !gd)) begin n_fail++; $display("FAIL no_ack_error: got done=%b err=%b expected done=0 err=1", gd, ge); end
        n_checks++;
        if (ba !== 1'b0) begin n_fail++; $display("FAIL no_ack_busy: got %b expected 0", ba); end
        repeat (10) @(negedge mclk);

        start_tx(8'hFF);
        fork
            dev_run(1'b1, 1'b0, bits, hi);
            wait_end(gd, ge, ba, pa);
        join
        n_checks++;
        if (bits !== 10'h3FF) begin n_fail++; $display("FAIL frame_FF: got %h expected 3ff", bits); end
        n_checks++;
        if (!(gd && !ge)) begin n_fail++; $display("FAIL done_FF: got done=%b err=%b expected done=1 err=0", gd, ge); end
        repeat (10) @(negedge mclk);
    endtask

    task automatic test_back_to_back();
        logic [9:0] bits;
        int hi;
        int d0;
        bit gd, ge;
        logic ba, pa;
        d0 = done_cnt;
        start_tx(8'h12);
        fork
            dev_run(1'b1, 1'b0, bits, hi);
            wait_end(gd, ge, ba, pa);
            begin
                repeat (300) @(negedge mclk);
                tx_data  = 8'hAA;
                tx_start = 1'b1;
                @(negedge mclk);
                tx_start = 1'b0;
            end
        join
        repeat (20) @(negedge mclk);
        n_checks++;
        if (bits !== 10'h312) begin n_fail++; $display("FAIL midframe_frame: got %h expected 312", bits); end
        n_checks++;
        if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL midframe_done_count: got %0d expected 1", done_cnt - d0); end
        n_checks++;
        if ({busy, ps2c_oe} !== 2'b00) begin n_fail++; $display("FAIL midframe_not_queued: got busy,ps2c_oe=%b expected 00", {busy, ps2c_oe}); end
    endtask

    task automatic test_reset_mid();
        logic [9:0] bits;
        int hi;
        int t;
        bit gd, ge;
        logic ba, pa;
        start_tx(8'h00);
        t = 0;
        while (ps2c_oe !== 1'b1 && t < BOUND) begin @(negedge mclk); t++; end
        while (ps2c_oe === 1'b1 && t < BOUND) begin @(negedge mclk); t++; end
        repeat (H) @(negedge mclk);
        for (int i = 0; i < 4; i++) begin
            dev_c = 1'b0;
            repeat (H) @(negedge mclk);
            if (i < 3) begin
                dev_c = 1'b1;
                repeat (H) @(negedge mclk);
            end
        end
        n_checks++;
        if ({busy, ps2d_oe} !== 2'b11) begin n_fail++; $display("FAIL bit3_driven: got busy,ps2d_oe=%b expected 11", {busy, ps2d_oe}); end
        rst = 1'b1;
        @(negedge mclk);
        n_checks++;
        if ({ps2c_oe, ps2d_oe, busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_mid_frame: got %b expected 000", {ps2c_oe, ps2d_oe, busy});
        end
        rst   = 1'b0;
        dev_c = 1'b1;
        repeat (20) @(negedge mclk);

        start_tx(8'h5A);
        fork
            dev_run(1'b1, 1'b1, bits, hi);
            wait_end(gd, ge, ba, pa);
        join
        n_checks++;
        if (bits !== 10'h35A) begin n_fail++; $display("FAIL glitch_frame: got %h expected 35a", bits); end
        n_checks++;
        if (!(gd && !ge)) begin n_fail++; $display("FAIL glitch_done: got done=%b err=%b expected done=1 err=0", gd, ge); end
        repeat (10) @(negedge mclk);
    endtask

    initial begin
        rst      = 1'b1;
        tx_data  = 8'h00;
        tx_start = 1'b0;
        dev_c    = 1'b1;
        dev_d    = 1'b1;
        test_reset();
        test_basic();
        test_parity();
        test_timeout();
        test_no_ack();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
